// File: rtl/dmem_arbiter_pkg.sv
// Shared widths, FSM encodings and port count for the data-memory arbiter.
// XLEN / ADDR_SIZE mirror the core-wide defines so the arbiter matches the datapath.
package dmem_arbiter_pkg;

    localparam int XLEN        = 32;
    localparam int ADDR_SIZE   = 32;
    localparam int DARB_NPORTS = 2;
    localparam int DARB_PORT_W = $clog2(DARB_NPORTS);

    typedef enum logic [1:0] {
        DARB_IDLE   = 2'd0,
        DARB_ACCESS = 2'd1,
        DARB_RESP   = 2'd2
    } darb_state_t;

endpackage

// File: rtl/dmem_arbiter_arb2_sel.sv
// Two-way grant selector: at most one sel bit high, purely combinational, no state.
// DMEM_ARB_RR_EN: a tie goes to the port not granted last; otherwise port 0 always wins.
module arb2_sel (
    input  logic req0,
    input  logic req1,
    input  logic last,
    output logic sel0,
    output logic sel1
);

`ifdef DMEM_ARB_RR_EN
    // last = 1 means port 1 won the previous grant, so port 0 takes the tie
    assign sel0 = req0 & (~req1 | last);
    assign sel1 = req1 & (~req0 | ~last);
`else
    logic w_unused_last;
    assign w_unused_last = last;
    assign sel0 = req0;
    assign sel1 = req1 & ~req0;
`endif

endmodule

// File: rtl/dmem_arbiter.sv
// Shares one data-memory port between the core (port 0) and loader/debug (port 1).
// gnt at T (IDLE only, requesters hold until gnt), memory access T+1, rvalid T+2; tie policy via DMEM_ARB_RR_EN.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
(
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 req0,
    input  logic                 req1,
    input  logic                 we0,
    input  logic                 we1,
    input  logic [XLEN-1:0]      addr0,
    input  logic [XLEN-1:0]      addr1,
    input  logic [XLEN-1:0]      wdata0,
    input  logic [XLEN-1:0]      wdata1,
    input  logic [ADDR_SIZE-1:0] pc0,
    input  logic [ADDR_SIZE-1:0] pc1,
    output logic                 gnt0,
    output logic                 gnt1,
    output logic                 rvalid0,
    output logic                 rvalid1,
    output logic [XLEN-1:0]      rdata0,
    output logic [XLEN-1:0]      rdata1,
    output logic                 m_we,
    output logic [XLEN-1:0]      m_a,
    output logic [XLEN-1:0]      m_wd,
    output logic [ADDR_SIZE-1:0] m_pc,
    input  logic [XLEN-1:0]      m_rd
);

    darb_state_t            r_state;
    logic [DARB_PORT_W-1:0] r_port;
    logic                   w_sel0;
    logic                   w_sel1;
    logic                   w_last;
    logic                   w_grant;

    arb2_sel u_arb2_sel (
        .req0 (req0),
        .req1 (req1),
        .last (w_last),
        .sel0 (w_sel0),
        .sel1 (w_sel1)
    );

    assign gnt0    = (r_state == DARB_IDLE) & w_sel0;
    assign gnt1    = (r_state == DARB_IDLE) & w_sel1;
    assign w_grant = gnt0 | gnt1;

`ifdef DMEM_ARB_RR_EN
    logic r_last;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_last <= 1'b1;
        end else if (w_grant) begin
            r_last <= gnt1;
        end
    end

    assign w_last = r_last;
`else
    assign w_last = 1'b1;
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= DARB_IDLE;
            r_port  <= '0;
            m_we    <= 1'b0;
            m_a     <= '0;
            m_wd    <= '0;
            m_pc    <= '0;
            rvalid0 <= 1'b0;
            rvalid1 <= 1'b0;
            rdata0  <= '0;
            rdata1  <= '0;
        end else begin
            // completion outputs are single-cycle pulses; m_we is high only in ACCESS
            m_we    <= 1'b0;
            rvalid0 <= 1'b0;
            rvalid1 <= 1'b0;
            rdata0  <= '0;
            rdata1  <= '0;
            case (r_state)
                DARB_IDLE: begin
                    if (w_grant) begin
                        r_state <= DARB_ACCESS;
                        r_port  <= gnt1;
                        m_we    <= gnt1 ? we1    : we0;
                        m_a     <= gnt1 ? addr1  : addr0;
                        m_wd    <= gnt1 ? wdata1 : wdata0;
                        m_pc    <= gnt1 ? pc1    : pc0;
                    end
                end
                DARB_ACCESS: begin
                    r_state <= DARB_RESP;
                    rvalid0 <= (r_port == 1'b0);
                    rvalid1 <= (r_port == 1'b1);
                    if (r_port == 1'b0) begin
                        rdata0 <= m_we ? '0 : m_rd;
                    end else begin
                        rdata1 <= m_we ? '0 : m_rd;
                    end
                end
                DARB_RESP: begin
                    r_state <= DARB_IDLE;
                end
                default: begin
                    r_state <= DARB_IDLE;
                end
            endcase
        end
    end

endmodule
